k2_run_controller: RTL

K2_RUN_CONTROLLER -- requirements
Module: k2_run_controller

---
 rtl/k2_ctrl_pkg.sv | 21 ++
 rtl/k2_halt_detector.sv | 53 +++++
 rtl/k2_run_controller.sv | 123 ++++++++++++
 3 files changed

// File: rtl/k2_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : k2_ctrl_pkg
//  Description : Shared types and constants for the K2 run controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package k2_ctrl_pkg;

  // Run controller sequencing states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CORE_RST = 2'd1,
    ST_RUN      = 2'd2,
    ST_FINISH   = 2'd3
  } k2_run_state_t;

  // Number of cycles the processor is held in reset before each run
  localparam int CORE_RST_CYCLES = 2;

endpackage : k2_ctrl_pkg
`default_nettype wire

// File: rtl/k2_halt_detector.sv
`default_nettype none
// ============================================================================
//  Module      : k2_halt_detector
//  Description : Detects a processor parked on a jump-to-self: the program
//                address matches its previous value on two consecutive RUN
//                cycles. The first RUN cycle has no predecessor and is never
//                compared.
//  Revision    : 1.0 - initial release
// ============================================================================
module k2_halt_detector (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_run,
  input  logic [3:0] i_addr,
  output logic       o_halt
);

  // Consecutive matches needed before the processor is considered halted
  localparam logic [1:0] c_STABLE_MATCHES = 2'd2;

  logic [3:0] r_prev_addr;
  logic       r_prev_vld;
  logic [1:0] r_match_cnt;
  logic       w_same;

  // A comparison is only meaningful once a RUN-cycle address has been stored
  assign w_same = i_run && r_prev_vld && (i_addr == r_prev_addr);

  // Halt is decided combinationally so the controller can act in this cycle
  assign o_halt = w_same && (r_match_cnt == (c_STABLE_MATCHES - 2'd1));

  // Track the previous address and count consecutive matches while running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_addr <= 4'd0;
      r_prev_vld  <= 1'b0;
      r_match_cnt <= 2'd0;
    end else if (!i_run) begin
      r_prev_vld  <= 1'b0;
      r_match_cnt <= 2'd0;
    end else begin
      r_prev_addr <= i_addr;
      r_prev_vld  <= 1'b1;
      if (!w_same) begin
        r_match_cnt <= 2'd0;
      end else if (r_match_cnt != c_STABLE_MATCHES) begin
        r_match_cnt <= r_match_cnt + 2'd1;
      end
    end
  end

endmodule : k2_halt_detector
`default_nettype wire

// File: rtl/k2_run_controller.sv
`default_nettype none
// ============================================================================
//  Module      : k2_run_controller
//  Description : Sequences one program run on an attached processor: selects
//                a program ROM, pulses the processor reset, lets it run until
//                it parks on a jump-to-self or the watchdog expires, then
//                captures the processor output and reports completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module k2_run_controller
  import k2_ctrl_pkg::*;
#(
  parameter  int BITS       = 8,
  parameter  int NPROG      = 4,
  parameter  int MAX_CYCLES = 200,
  localparam int SEL_W      = (NPROG > 1) ? $clog2(NPROG) : 1,
  localparam int CNT_W      = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [SEL_W-1:0]   prog_sel,
  input  logic [3:0]         core_addr,
  input  logic [NPROG*8-1:0] rom_data,
  output logic [7:0]         core_inst,
  output logic               core_rst_n,
  input  logic [BITS-1:0]    core_ro,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [BITS-1:0]    result
);

  localparam logic [1:0]       c_RST_LAST = 2'(CORE_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CYC_LAST = CNT_W'(MAX_CYCLES - 1);

  k2_run_state_t    r_state;
  logic [SEL_W-1:0] r_sel_q;
  logic [1:0]       r_rst_cnt;
  logic [CNT_W-1:0] r_cyc_cnt;
  logic             w_run;
  logic             w_halt;

  assign w_run = (r_state == ST_RUN);

  k2_halt_detector u_halt_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_run  (w_run),
    .i_addr (core_addr),
    .o_halt (w_halt)
  );

  // Instruction mux from the latched program select; unmatched selects give 0
  always_comb begin
    core_inst = 8'h00;
    for (int k = 0; k < NPROG; k++) begin
      if (r_sel_q == SEL_W'(k)) begin
        core_inst = rom_data[8*k +: 8];
      end
    end
  end

  // Run sequencer with registered processor reset and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_sel_q    <= '0;
      r_rst_cnt  <= 2'd0;
      r_cyc_cnt  <= '0;
      core_rst_n <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      result     <= '0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sel_q   <= prog_sel;
            timeout   <= 1'b0;
            r_rst_cnt <= 2'd0;
            busy      <= 1'b1;
            r_state   <= ST_CORE_RST;
          end
        end
        ST_CORE_RST: begin
          if (r_rst_cnt == c_RST_LAST) begin
            core_rst_n <= 1'b1;
            r_cyc_cnt  <= '0;
            r_state    <= ST_RUN;
          end else begin
            r_rst_cnt <= r_rst_cnt + 2'd1;
          end
        end
        ST_RUN: begin
          // A halt seen on the watchdog's last cycle still counts as a halt
          if (w_halt || (r_cyc_cnt == c_CYC_LAST)) begin
            core_rst_n <= 1'b0;
            done       <= 1'b1;
            result     <= core_ro;
            timeout    <= ~w_halt;
            r_state    <= ST_FINISH;
          end else begin
            r_cyc_cnt <= r_cyc_cnt + 1'b1;
          end
        end
        ST_FINISH: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          core_rst_n <= 1'b0;
          busy       <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : k2_run_controller
`default_nettype wire
